// File: rtl/wbc_pkg.sv
// Shared types and defaults for the wbc round controller.
// Optional feature macro: WBC_OUT_PARITY_EN (per-byte even parity on the output block).
package wbc_pkg;

    localparam int WBC_N  = 128;
    localparam int WBC_NR = 10;
    localparam int WBC_RW = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ROUND,
        FINAL,
        DONE
    } wbc_state_e;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    localparam logic [2:0] ALG_MODE_0 = 3'b000;
    localparam logic [2:0] ALG_MODE_3 = 3'b011;

    // Even parity bit for one byte: set when the byte has an odd number of ones.
    function automatic logic parity8(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/wbc_key_addr_gen.sv
// Round-key address generator: up counter for encrypt, down counter for decrypt.
// The start index is presented combinationally in the accept cycle so the RAM read
// can launch without waiting for the mode register.
module wbc_key_addr_gen
    import wbc_pkg::*;
#(
    parameter int NR = WBC_NR,
    parameter int RW = WBC_RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic          adv,
    output logic [RW-1:0] addr,
    output logic          last
);

    localparam logic [RW-1:0] IDX_HI = RW'(NR);

    logic [RW-1:0] idx_q;
    logic          dec_q;
    logic [RW-1:0] first_idx;
    logic [RW-1:0] last_idx;

    // Start index and terminal index depend on direction.
    always_comb begin
        first_idx = (mode == MODE_DEC) ? IDX_HI : '0;
        last_idx  = dec_q ? '0 : IDX_HI;
        last      = (idx_q == last_idx);
        addr      = start ? first_idx : idx_q;
    end

    // The start cycle already issues the first index, so the register loads the second one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            dec_q <= 1'b0;
        end else if (start) begin
            dec_q <= mode;
            idx_q <= (mode == MODE_DEC) ? (IDX_HI - 1'b1) : {{(RW-1){1'b0}}, 1'b1};
        end else if (adv) begin
            idx_q <= dec_q ? (idx_q - 1'b1) : (idx_q + 1'b1);
        end
    end

endmodule

// File: rtl/wbc_round_ctrl.sv
// Iterative round controller around an external non-linear transform.
// Key RAM is sync-read (1 cycle); the transform is combinational from nlt_rec/nlt_rki.
// Optional macro WBC_OUT_PARITY_EN adds out_par, even parity per byte of out_data.
module wbc_round_ctrl
    import wbc_pkg::*;
#(
    parameter int N  = WBC_N,
    parameter int NR = WBC_NR,
    parameter int RW = WBC_RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          in_mode,
    input  logic [2:0]    in_alg,
    output logic [RW-1:0] rk_addr,
    output logic          rk_rd,
    input  logic [N-1:0]  rk_data,
    output logic [N-1:0]  nlt_rki,
    output logic [N-1:0]  nlt_rec,
    output logic          nlt_mode,
    output logic [2:0]    nlt_alg,
    input  logic [N-1:0]  nlt_nto,
    input  logic [N-1:0]  nlt_rko,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data
`ifdef WBC_OUT_PARITY_EN
    ,
    output logic [N/8-1:0] out_par
`endif
);

    wbc_state_e    state_q, state_d;
    logic [N-1:0]  blk_q;
    logic          mode_q;
    logic [2:0]    alg_q;
    logic [RW-1:0] round_q;
    logic          accept;
    logic          last_round;
    logic          kg_adv;
    logic          kg_last;

    assign last_round = (round_q == RW'(NR - 1));
    assign nlt_rki    = rk_data;
    assign nlt_rec    = blk_q;
    assign nlt_mode   = mode_q;
    assign nlt_alg    = alg_q;

    wbc_key_addr_gen #(.NR(NR), .RW(RW)) u_key_addr (
        .clk   (clk),
        .rst   (rst),
        .start (accept),
        .mode  (in_mode),
        .adv   (kg_adv),
        .addr  (rk_addr),
        .last  (kg_last)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = FETCH;
            FETCH:   state_d = ROUND;
            ROUND:   if (last_round) state_d = FINAL;
            FINAL:   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: the last round needs no read since FINAL reuses the held RAM output.
    always_comb begin
        in_ready = (state_q == IDLE);
        accept   = in_ready & in_valid;
        case (state_q)
            IDLE:    rk_rd = accept;
            FETCH:   rk_rd = 1'b1;
            ROUND:   rk_rd = ~last_round;
            default: rk_rd = 1'b0;
        endcase
        kg_adv = rk_rd & ~accept & ~kg_last;
    end

    // Block state, latched controls and round counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_q   <= '0;
            mode_q  <= MODE_ENC;
            alg_q   <= ALG_MODE_0;
            round_q <= '0;
        end else if (accept) begin
            blk_q   <= in_data;
            mode_q  <= in_mode;
            alg_q   <= in_alg;
            round_q <= '0;
        end else if (state_q == ROUND) begin
            blk_q   <= nlt_nto;
            round_q <= round_q + 1'b1;
        end
    end

    // Output register: whitening result captured in FINAL, held until out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (state_q == FINAL) begin
            out_data  <= nlt_rko;
            out_valid <= 1'b1;
        end else if (state_q == DONE && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef WBC_OUT_PARITY_EN
    logic [N/8-1:0] par_d;

    // Per-byte parity of the value about to be captured into out_data.
    always_comb begin
        for (int i = 0; i < N/8; i++) par_d[i] = parity8(nlt_rko[i*8 +: 8]);
    end

    // Parity register tracks out_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  out_par <= '0;
        else if (state_q == FINAL) out_par <= par_d;
    end
`endif

endmodule

// File: tb/tb_wbc_round_ctrl.sv
// Self-checking bench for wbc_round_ctrl with a key RAM and a toy transform.
module tb_wbc_round_ctrl;

    localparam int N  = 128;
    localparam int NR = 10;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_data = '0;
    logic          in_mode = 1'b0;
    logic [2:0]    in_alg = 3'b000;
    logic [RW-1:0] rk_addr;
    logic          rk_rd;
    logic [N-1:0]  rk_data = '0;
    logic [N-1:0]  nlt_rki, nlt_rec, nlt_nto, nlt_rko;
    logic          nlt_mode;
    logic [2:0]    nlt_alg;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  out_data;
`ifdef WBC_OUT_PARITY_EN
    logic [N/8-1:0] out_par;
`endif

    int total = 0;
    int bad   = 0;
    logic [N-1:0] keys [0:15];

    wbc_round_ctrl #(.N(N), .NR(NR), .RW(RW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_alg    (in_alg),
        .rk_addr   (rk_addr),
        .rk_rd     (rk_rd),
        .rk_data   (rk_data),
        .nlt_rki   (nlt_rki),
        .nlt_rec   (nlt_rec),
        .nlt_mode  (nlt_mode),
        .nlt_alg   (nlt_alg),
        .nlt_nto   (nlt_nto),
        .nlt_rko   (nlt_rko),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef WBC_OUT_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    always #5 clk = ~clk;

    // Sync-read key RAM; output holds when not read.
    always @(posedge clk) if (rk_rd) rk_data <= keys[rk_addr];

    function automatic logic [N-1:0] tf(input logic [N-1:0] rec, input logic [N-1:0] rki,
                                        input logic mode, input logic [2:0] alg);
        logic [N-1:0] r;
        r = mode ? {rec[0], rec[N-1:1]} : {rec[N-2:0], rec[N-1]};
        return r ^ rki ^ {{(N-3){1'b0}}, alg};
    endfunction

    assign nlt_nto = tf(nlt_rec, nlt_rki, nlt_mode, nlt_alg);
    assign nlt_rko = nlt_rki ^ nlt_rec;

    // Reference: key index list by direction; round r consumes list[r+1] (the accept-cycle
    // read lands during the wait cycle), and whitening reuses list[NR].
    function automatic int key_idx(input logic mode, input int i);
        return mode ? (NR - i) : i;
    endfunction

    function automatic logic [N-1:0] ref_block(input logic [N-1:0] d, input logic mode,
                                               input logic [2:0] alg);
        logic [N-1:0] st;
        st = d;
        for (int r = 0; r < NR; r++) st = tf(st, keys[key_idx(mode, r + 1)], mode, alg);
        return st ^ keys[key_idx(mode, NR)];
    endfunction

    function automatic logic [N/8-1:0] ref_par(input logic [N-1:0] d);
        logic [N/8-1:0] p;
        for (int i = 0; i < N/8; i++) p[i] = ^d[i*8 +: 8];
        return p;
    endfunction

    function automatic logic [N-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Run one block end to end; hold out_ready low for 'hold' cycles in DONE.
    task automatic run_block(input logic [N-1:0] d, input logic mode, input logic [2:0] alg,
                             input int hold, output logic [N-1:0] result);
        int addrs[$];
        int cyc;
        logic [N-1:0] exp;
        exp = ref_block(d, mode, alg);
        @(negedge clk);
        check("idle_ready", {127'b0, in_ready}, 1);
        in_valid = 1'b1; in_data = d; in_mode = mode; in_alg = alg;
        #1;
        check("acc_rd", {127'b0, rk_rd}, 1);
        if (rk_rd) addrs.push_back(int'(rk_addr));
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
            in_valid = 1'b0;
            in_data = rnd128(); in_mode = ~mode; in_alg = ~alg;
            #1;
            if (rk_rd) addrs.push_back(int'(rk_addr));
        end
        check("latency", N'(cyc), N'(NR + 3));
        check("addr_cnt", N'(addrs.size()), N'(NR + 1));
        for (int i = 0; i < addrs.size() && i <= NR; i++)
            check($sformatf("addr%0d", i), N'(addrs[i]), N'(key_idx(mode, i)));
        check("out_data", out_data, exp);
        check("nlt_mode", {127'b0, nlt_mode}, {127'b0, mode});
        check("nlt_alg", {125'b0, nlt_alg}, {125'b0, alg});
`ifdef WBC_OUT_PARITY_EN
        check("out_par", {{(N - N/8){1'b0}}, out_par}, {{(N - N/8){1'b0}}, ref_par(exp)});
`endif
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            @(negedge clk);
            check("hold_valid", {127'b0, out_valid}, 1);
            check("hold_data", out_data, exp);
            check("hold_ready", {127'b0, in_ready}, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("rel_valid", {127'b0, out_valid}, 0);
        check("rel_ready", {127'b0, in_ready}, 1);
        check("rel_rd", {127'b0, rk_rd}, 0);
        result = out_data;
    endtask

    initial begin
        logic [N-1:0] pt, ct, res;
        for (int i = 0; i < 16; i++) keys[i] = rnd128();

        // Reset behaviour
        repeat (3) @(negedge clk);
        check("rst_ready", {127'b0, in_ready}, 1);
        check("rst_valid", {127'b0, out_valid}, 0);
        check("rst_rd", {127'b0, rk_rd}, 0);
        check("rst_data", out_data, '0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", {127'b0, out_valid}, 0);

        // Encrypt, then decrypt the resulting ciphertext
        pt = rnd128();
        run_block(pt, 1'b0, 3'b000, 0, ct);
        run_block(ct, 1'b1, 3'b000, 0, res);

        // Stall in DONE with in_valid asserted
        run_block(rnd128(), 1'b0, 3'b011, 5, res);

        // Reset pulse during round 4
        @(negedge clk);
        in_valid = 1'b1; in_data = rnd128(); in_mode = 1'b0; in_alg = 3'b001;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {127'b0, out_valid}, 0);
        check("mid_rst_ready", {127'b0, in_ready}, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_idle", {127'b0, in_ready}, 1);
        check("mid_rst_rd", {127'b0, rk_rd}, 0);
        check("mid_rst_data", out_data, '0);

        // Recovery and random blocks
        run_block(rnd128(), 1'b1, 3'b010, 0, res);
        for (int k = 0; k < 4; k++)
            run_block(rnd128(), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      int'($urandom_range(0, 3)), res);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
